// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : map_pkg
// Description : Shared definitions for the Sokoban map path: cell codes, map
//               geometry, 640x480@60 VGA timing constants and the colour
//               palette used by the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package map_pkg;

    // Map geometry
    localparam int MAP_W      = 8;
    localparam int MAP_H      = 7;
    localparam int CELL_BITS  = 4;
    localparam int MAP_CELLS  = MAP_W * MAP_H;
    localparam int MAP_BITS   = MAP_CELLS * CELL_BITS;
    localparam int TILE_SIZE  = 32;
    localparam int MAP_PIX_W  = MAP_W * TILE_SIZE;
    localparam int MAP_PIX_H  = MAP_H * TILE_SIZE;

    // Cell codes (also consumed by map_display)
    localparam logic [3:0] CELL_FLOOR      = 4'd0;
    localparam logic [3:0] CELL_WALL       = 4'd1;
    localparam logic [3:0] CELL_BOX        = 4'd2;
    localparam logic [3:0] CELL_TARGET     = 4'd3;
    localparam logic [3:0] CELL_PLAYER     = 4'd4;
    localparam logic [3:0] CELL_BOX_TGT    = 4'd5;
    localparam logic [3:0] CELL_PLAYER_TGT = 4'd6;

    // VGA 640x480@60 timing, in pixel ticks / lines
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    typedef logic [11:0] rgb_t;

    // Palette
    localparam rgb_t RGB_BLACK      = 12'h000;
    localparam rgb_t RGB_FLOOR      = 12'h222;
    localparam rgb_t RGB_WALL       = 12'h888;
    localparam rgb_t RGB_BOX        = 12'hA50;
    localparam rgb_t RGB_TARGET     = 12'h0A0;
    localparam rgb_t RGB_PLAYER     = 12'h00F;
    localparam rgb_t RGB_BOX_TGT    = 12'hFF0;
    localparam rgb_t RGB_PLAYER_TGT = 12'h0AF;
    localparam rgb_t RGB_WIN        = 12'h0F0;
    localparam rgb_t RGB_INVALID    = 12'hF0F;

    function automatic rgb_t palette(input logic [3:0] code);
        rgb_t c;
        case (code)
            CELL_FLOOR:      c = RGB_FLOOR;
            CELL_WALL:       c = RGB_WALL;
            CELL_BOX:        c = RGB_BOX;
            CELL_TARGET:     c = RGB_TARGET;
            CELL_PLAYER:     c = RGB_PLAYER;
            CELL_BOX_TGT:    c = RGB_BOX_TGT;
            CELL_PLAYER_TGT: c = RGB_PLAYER_TGT;
            default:         c = RGB_INVALID;   // corrupt map data stands out
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Pixel-tick divider plus 800x525 horizontal/vertical counters
//               with raw (undelayed) sync and visible-area decode.
// Ports       : clk, rst_n        - clock, async active-low reset
//               pix_tick_o        - one-clk enable every CLK_DIV clocks
//               h_o, v_o          - current pixel column / line
//               hsync_raw_o/vsync_raw_o - active-low sync from the counters
//               visible_o         - counters inside 640x480 active area
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import map_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick_o,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o,
    output logic       visible_o
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;

    always_comb begin
        pix_tick_o = (div_q == DIV_LAST);
        div_d      = pix_tick_o ? '0 : div_q + DIV_W'(1);
        h_d        = h_q;
        v_d        = v_q;
        if (pix_tick_o) begin
            if (h_q == H_TOTAL - 10'd1) begin
                h_d = '0;
                v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign h_o         = h_q;
    assign v_o         = v_q;
    assign hsync_raw_o = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    assign vsync_raw_o = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    assign visible_o   = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);

endmodule
`default_nettype wire

// File: rtl/map_vga_render.sv
`default_nettype none
// ============================================================================
// Module      : map_vga_render
// Description : Draws the 8x7 Sokoban cell map on a 640x480@60 VGA display.
//               The map and win flag are snapshotted once per frame in
//               vertical blanking; colour and sync share a 2-tick pipeline.
// Ports       : clk, rst_n        - clock, async active-low reset
//               map_data_in[223:0]- 56 cells x 4 bits, row-major, (0,0) in [3:0]
//               win_flag          - stage solved (green border)
//               hsync, vsync      - active-low sync, aligned with colour
//               vga_r/g/b[3:0]    - pixel colour
//               frame_start       - one-clk pulse after each snapshot
// Revision    : 1.0 - initial release
// ============================================================================
module map_vga_render
    import map_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int X0      = 192,
    parameter int Y0      = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAP_BITS-1:0] map_data_in,
    input  logic                win_flag,
    output logic                hsync,
    output logic                vsync,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b,
    output logic                frame_start
);

    localparam logic [9:0] MAP_X0 = 10'(X0);
    localparam logic [9:0] MAP_X1 = 10'(X0 + MAP_PIX_W);
    localparam logic [9:0] MAP_Y0 = 10'(Y0);
    localparam logic [9:0] MAP_Y1 = 10'(Y0 + MAP_PIX_H);

    logic       pix_tick;
    logic [9:0] h, v;
    logic       hsync_raw, vsync_raw, visible;

    vga_timing #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick_o  (pix_tick),
        .h_o         (h),
        .v_o         (v),
        .hsync_raw_o (hsync_raw),
        .vsync_raw_o (vsync_raw),
        .visible_o   (visible)
    );

    // ---------------- frame snapshot ----------------
    logic [MAP_BITS-1:0] map_q;
    logic                win_q;
    logic                frame_start_q;
    logic                snap;

    assign snap = pix_tick && (h == 10'd0) && (v == V_VISIBLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q         <= '0;
            win_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= snap;
            if (snap) begin
                map_q <= map_data_in;
                win_q <= win_flag;
            end
        end
    end

    // ---------------- tile decode ----------------
    // Offsets are only meaningful inside the map; the low 8 bits cover the
    // full 256-pixel extent (col/row in [7:5], tile position in [4:0]).
    logic [7:0]   dx, dy;
    logic         in_map, grid;
    logic [5:0]   cell_idx;
    logic [255:0] map_ext;
    logic [3:0]   cell_code;

    assign dx       = 8'(h - MAP_X0);
    assign dy       = 8'(v - MAP_Y0);
    assign in_map   = (h >= MAP_X0) && (h < MAP_X1) && (v >= MAP_Y0) && (v < MAP_Y1);
    assign grid     = (dx[4:0] == 5'd0) || (dy[4:0] == 5'd0);
    assign cell_idx = {dy[7:5], dx[7:5]};          // row*8 + col
    // Zero-padded to 64 cells so an out-of-map index never selects past the end.
    assign map_ext  = 256'(map_q);
    assign cell_code = map_ext[{cell_idx, 2'b00} +: CELL_BITS];

    // ---------------- stage 1 ----------------
    logic       in_map_q, grid_q, blank_q, hs1_q, vs1_q;
    logic [3:0] code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_map_q <= 1'b0;
            grid_q   <= 1'b0;
            blank_q  <= 1'b1;
            code_q   <= CELL_FLOOR;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
        end else if (pix_tick) begin
            in_map_q <= in_map;
            grid_q   <= grid;
            blank_q  <= !visible;
            code_q   <= cell_code;
            hs1_q    <= hsync_raw;
            vs1_q    <= vsync_raw;
        end
    end

    // ---------------- stage 2 ----------------
    rgb_t rgb_d, rgb_q;
    logic hsync_q, vsync_q;

    always_comb begin
        rgb_d = RGB_BLACK;
        if (blank_q) begin
            rgb_d = RGB_BLACK;
        end else if (in_map_q && grid_q) begin
            rgb_d = RGB_BLACK;
        end else if (in_map_q) begin
            rgb_d = palette(code_q);
        end else if (win_q) begin
            rgb_d = RGB_WIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= RGB_BLACK;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (pix_tick) begin
            rgb_q   <= rgb_d;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
